alu_sequencer: RTL and testbench

- Issue-side controller for the 16-bit `alu` block; drives that block's inputs and consumes its outputs.
- Holds a small register file and a carry/compare flag pair.
- Accepts one register-to-register instruction through a valid/ready handshake and registers the ALU operands.
- Writes the ALU result back to the register file and presents it on a valid/ready result channel.
- Sits between the instruction source and the combinational `alu`.

---
 rtl/alu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller for a combinational 16-bit alu.
// Holds a small register file plus carry/compare flags. It accepts one
// register-to-register instruction per valid/ready handshake, registers
// the alu operands, writes the alu result back and returns it on a
// valid/ready result channel.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   instr_*                  instruction channel (valid/ready + fields)
//   ld_en/ld_addr/ld_data    direct register-file load, any state
//   alu_in_a..alu_carry_in   registered drive to the alu
//   alu_out/carry/compare    alu results, consumed in EXEC
//   res_*                    result channel (valid/ready + data, dst)
//   carry_flag, compare_flag status flags
//   rd_addr/rd_data          combinational debug read port
module alu_sequencer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned REG_COUNT = 8,
    parameter int unsigned ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_select,
    input  logic              instr_mode,
    input  logic              instr_use_carry,
    input  logic [ADDR_W-1:0] instr_src_a,
    input  logic [ADDR_W-1:0] instr_src_b,
    input  logic [ADDR_W-1:0] instr_dst,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [3:0]        alu_select,
    output logic              alu_mode,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry_out,
    input  logic              alu_compare,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] res_dst,
    output logic              carry_flag,
    output logic              compare_flag,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              writeback;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] rf [REG_COUNT];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Addresses past the end of the register file read as 0 and drop writes.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < REG_COUNT;
    endfunction

    assign op_a    = in_range(instr_src_a) ? rf[instr_src_a] : '0;
    assign op_b    = in_range(instr_src_b) ? rf[instr_src_b] : '0;
    assign rd_data = in_range(rd_addr)     ? rf[rd_addr]     : '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        writeback = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                writeback = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state, so instr_ready
    // first rises one cycle after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            instr_ready <= (state_d == IDLE);
            res_valid   <= (state_d == RESP);
        end
    end

    // Operand capture on accept; result and flag capture in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in_a     <= '0;
            alu_in_b     <= '0;
            alu_select   <= '0;
            alu_mode     <= 1'b0;
            alu_carry_in <= 1'b0;
            dst_q        <= '0;
            res_data     <= '0;
            res_dst      <= '0;
            carry_flag   <= 1'b0;
            compare_flag <= 1'b0;
        end else begin
            if (accept) begin
                alu_in_a     <= op_a;
                alu_in_b     <= op_b;
                alu_select   <= instr_select;
                alu_mode     <= instr_mode;
                alu_carry_in <= instr_use_carry & carry_flag;
                dst_q        <= instr_dst;
            end
            if (writeback) begin
                res_data     <= alu_out;
                res_dst      <= dst_q;
                compare_flag <= alu_compare;
                // Logic-mode carry out is meaningless, so the flag holds.
                if (alu_mode) begin
                    carry_flag <= alu_carry_out;
                end
            end
        end
    end

    // Register file: the alu writeback is placed last so it wins over a
    // colliding direct load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (ld_en && in_range(ld_addr)) begin
                rf[ld_addr] <= ld_data;
            end
            if (writeback && in_range(dst_q)) begin
                rf[dst_q] <= alu_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. Models the external alu
// (74181-style function table) and keeps a register-file/flag reference.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_select;
    logic        instr_mode;
    logic        instr_use_carry;
    logic [2:0]  instr_src_a;
    logic [2:0]  instr_src_b;
    logic [2:0]  instr_dst;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_in_a;
    logic [15:0] alu_in_b;
    logic [3:0]  alu_select;
    logic        alu_mode;
    logic        alu_carry_in;
    logic [15:0] alu_out;
    logic        alu_carry_out;
    logic        alu_compare;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_dst;
    logic        carry_flag;
    logic        compare_flag;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state.
    logic [15:0] m_rf [8];
    logic        m_carry;
    logic        m_cmp;
    logic [15:0] exp_res;

    alu_sequencer #(.DATA_W(16), .REG_COUNT(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_select(instr_select), .instr_mode(instr_mode),
        .instr_use_carry(instr_use_carry),
        .instr_src_a(instr_src_a), .instr_src_b(instr_src_b), .instr_dst(instr_dst),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_dst(res_dst),
        .carry_flag(carry_flag), .compare_flag(compare_flag),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #10 clk = ~clk;

    // External alu: returns {carry_out, compare, result}.
    function automatic logic [17:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] s, input logic m,
                                            input logic c);
        logic [15:0] f;
        logic [16:0] x;
        logic [16:0] y;
        logic [16:0] sum;
        logic        co;
        x = '0;
        y = '0;
        if (!m) begin
            case (s)
                4'h0: f = ~a;       4'h1: f = ~(a | b);
                4'h2: f = ~a & b;   4'h3: f = 16'h0000;
                4'h4: f = ~(a & b); 4'h5: f = ~b;
                4'h6: f = a ^ b;    4'h7: f = a & ~b;
                4'h8: f = ~a | b;   4'h9: f = ~(a ^ b);
                4'hA: f = b;        4'hB: f = a & b;
                4'hC: f = 16'hFFFF; 4'hD: f = a | ~b;
                4'hE: f = a | b;    default: f = a;
            endcase
            co = a[15] ^ b[0];
        end else begin
            case (s)
                4'h0: begin x = {1'b0, a};      y = 17'h0;          end
                4'h1: begin x = {1'b0, a | b};  y = 17'h0;          end
                4'h2: begin x = {1'b0, a | ~b}; y = 17'h0;          end
                4'h3: begin x = 17'h0;          y = 17'h0FFFF;      end
                4'h4: begin x = {1'b0, a};      y = {1'b0, a & ~b}; end
                4'h5: begin x = {1'b0, a | b};  y = {1'b0, a & ~b}; end
                4'h6: begin x = {1'b0, a};      y = {1'b0, ~b};     end
                4'h7: begin x = {1'b0, a & ~b}; y = 17'h0FFFF;      end
                4'h8: begin x = {1'b0, a};      y = {1'b0, a & b};  end
                4'h9: begin x = {1'b0, a};      y = {1'b0, b};      end
                4'hA: begin x = {1'b0, a | ~b}; y = {1'b0, a & b};  end
                4'hB: begin x = {1'b0, a & b};  y = 17'h0FFFF;      end
                4'hC: begin x = {1'b0, a};      y = {1'b0, a};      end
                4'hD: begin x = {1'b0, a | b};  y = {1'b0, a};      end
                4'hE: begin x = {1'b0, a | ~b}; y = {1'b0, a};      end
                default: begin x = {1'b0, a};   y = 17'h0FFFF;      end
            endcase
            sum = x + y + {16'h0, c};
            f   = sum[15:0];
            co  = sum[16];
        end
        return {co, (a == b), f};
    endfunction

    always_comb begin
        logic [17:0] r;
        r             = ref_alu(alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in);
        alu_out       = r[15:0];
        alu_compare   = r[16];
        alu_carry_out = r[17];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
        m_carry = 1'b0;
        m_cmp   = 1'b0;
    endtask

    task automatic ld(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
        m_rf[a] = d;
    endtask

    // Drives one instruction through accept/EXEC/RESP, updating the model.
    // Optional loads in the accept and EXEC cycles; 'hold' RESP cycles with
    // res_ready low and a competing instr_valid asserted.
    task automatic run_instr(
        input logic [3:0] sel, input logic mode, input logic uc,
        input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] dst,
        input logic la_en, input logic [2:0] la_addr, input logic [15:0] la_data,
        input logic le_en, input logic [2:0] le_addr, input logic [15:0] le_data,
        input int hold,
        output int waited, output logic v_exec, output logic v_resp,
        output logic stable, output logic [15:0] o_data, output logic [2:0] o_dst);
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [17:0] r;
        waited = 0;
        v_exec = 1'bx; v_resp = 1'bx; stable = 1'b0; o_data = 'x; o_dst = 'x;
        while (instr_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        if (instr_ready !== 1'b1) begin
            waited = -1;
            return;
        end
        instr_valid = 1'b1; instr_select = sel; instr_mode = mode;
        instr_use_carry = uc; instr_src_a = sa; instr_src_b = sb; instr_dst = dst;
        ld_en = la_en; ld_addr = la_addr; ld_data = la_data;
        a   = m_rf[sa];
        b   = m_rf[sb];
        cin = uc & m_carry;
        tick();
        if (la_en) m_rf[la_addr] = la_data;
        instr_valid = 1'b0;
        ld_en = le_en; ld_addr = le_addr; ld_data = le_data;
        res_ready = 1'b1;
        v_exec = res_valid;
        r = ref_alu(a, b, sel, mode, cin);
        tick();
        ld_en = 1'b0;
        if (le_en) m_rf[le_addr] = le_data;
        m_rf[dst] = r[15:0];
        m_cmp     = r[16];
        if (mode) m_carry = r[17];
        exp_res   = r[15:0];
        v_resp = res_valid;
        o_data = res_data;
        o_dst  = res_dst;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            instr_valid = 1'b1; instr_select = ~sel; instr_dst = dst + 3'd1;
            tick();
            if (res_valid !== 1'b1 || res_data !== o_data || res_dst !== o_dst ||
                instr_ready !== 1'b0)
                stable = 1'b0;
        end
        instr_valid = 1'b0;
        res_ready   = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    int          w;
    logic        ve;
    logic        vr;
    logic        st;
    logic [15:0] od;
    logic [2:0]  ot;

    task automatic test_reset();
        ld(3'd1, 16'hFFFF);
        for (int i = 2; i < 8; i++) ld(3'(i), 16'($urandom));
        run_instr(4'hC, 1'b1, 1'b0, 3'd1, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0, w, ve, vr, st, od, ot);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (instr_ready !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: ready=%b valid=%b want 0 0", instr_ready, res_valid);
        end
        n_vec++;
        if (carry_flag !== 1'b0 || compare_flag !== 1'b0 || res_data !== 16'h0 ||
            alu_in_a !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_regs: carry=%b cmp=%b res=%h in_a=%h want all 0",
                     carry_flag, compare_flag, res_data, alu_in_a);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_vec++;
            if (rd_data !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_rf[%0d]: got %h want 0000", i, rd_data);
            end
        end
        tick();
        rst_n = 1'b1;
        n_vec++;
        if (instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b want 0", instr_ready);
        end
        tick();
        n_vec++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_rise: got %b want 1", instr_ready);
        end
    endtask

    task automatic test_xor();
        ld(3'd1, 16'h1234);
        ld(3'd2, 16'h0F0F);
        run_instr(4'b0110, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 0, 0, 0, 0, 0, 0, 0, w, ve, vr, st, od, ot);
        rd_addr = 3'd3;
        #1;
        n_vec++;
        if (w !== 0 || ve !== 1'b0 || vr !== 1'b1) begin
            n_fail++;
            $display("FAIL xor_timing: wait=%0d v_exec=%b v_resp=%b want 0 0 1", w, ve, vr);
        end
        n_vec++;
        if (od !== 16'h1D3B || ot !== 3'd3 || rd_data !== 16'h1D3B) begin
            n_fail++;
            $display("FAIL xor_result: res=%h dst=%0d rf3=%h want 1d3b 3 1d3b", od, ot, rd_data);
        end
        n_vec++;
        if (carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL xor_carry_held: got %b want 0", carry_flag);
        end
    endtask

    task automatic test_arith();
        ld(3'd1, 16'hFFFF);
        ld(3'd2, 16'h0000);
        run_instr(4'b0101, 1'b1, 1'b0, 3'd1, 3'd2, 3'd4, 0, 0, 0, 0, 0, 0, 0, w, ve, vr, st, od, ot);
        rd_addr = 3'd4;
        #1;
        n_vec++;
        if (od !== 16'hFFFE || rd_data !== 16'hFFFE || carry_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL arith: res=%h rf4=%h carry=%b want fffe fffe 1", od, rd_data, carry_flag);
        end
        // Logic op whose alu carry_out is 0: flag must stay set.
        run_instr(4'b0000, 1'b0, 1'b0, 3'd2, 3'd2, 3'd5, 0, 0, 0, 0, 0, 0, 0, w, ve, vr, st, od, ot);
        n_vec++;
        if (carry_flag !== 1'b1 || od !== 16'hFFFF || compare_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL logic_after_arith: carry=%b res=%h cmp=%b want 1 ffff 1",
                     carry_flag, od, compare_flag);
        end
    endtask

    task automatic test_backpressure();
        ld(3'd6, 16'h1111);
        ld(3'd7, 16'h2222);
        run_instr(4'b1001, 1'b1, 1'b0, 3'd6, 3'd7, 3'd0, 0, 0, 0, 0, 0, 0, 5, w, ve, vr, st, od, ot);
        n_vec++;
        if (vr !== 1'b1 || st !== 1'b1 || od !== 16'h3333) begin
            n_fail++;
            $display("FAIL backpressure_hold: valid=%b stable=%b res=%h want 1 1 3333", vr, st, od);
        end
        run_instr(4'b1001, 1'b1, 1'b0, 3'd0, 3'd6, 3'd1, 0, 0, 0, 0, 0, 0, 0, w, ve, vr, st, od, ot);
        n_vec++;
        if (w !== 0 || od !== 16'h4444) begin
            n_fail++;
            $display("FAIL backpressure_next: wait=%0d res=%h want 0 4444", w, od);
        end
    endtask

    task automatic test_collision();
        ld(3'd1, 16'h0101);
        ld(3'd2, 16'h0202);
        run_instr(4'b1001, 1'b1, 1'b0, 3'd1, 3'd2, 3'd6, 0, 0, 0, 1, 3'd6, 16'hAAAA, 0,
                  w, ve, vr, st, od, ot);
        rd_addr = 3'd6;
        #1;
        n_vec++;
        if (rd_data !== 16'h0303) begin
            n_fail++;
            $display("FAIL exec_ld_collision: rf6=%h want 0303", rd_data);
        end
        run_instr(4'b1001, 1'b1, 1'b0, 3'd1, 3'd2, 3'd7, 1, 3'd1, 16'h7777, 0, 0, 0, 0,
                  w, ve, vr, st, od, ot);
        rd_addr = 3'd1;
        #1;
        n_vec++;
        if (od !== 16'h0303 || rd_data !== 16'h7777) begin
            n_fail++;
            $display("FAIL accept_ld_src: res=%h rf1=%h want 0303 7777", od, rd_data);
        end
    endtask

    task automatic test_reset_exec();
        ld(3'd1, 16'hFFFF);
        ld(3'd2, 16'h0001);
        n_vec++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_exec_ready: got %b want 1", instr_ready);
        end
        instr_valid = 1'b1; instr_select = 4'b1001; instr_mode = 1'b1;
        instr_use_carry = 1'b0; instr_src_a = 3'd1; instr_src_b = 3'd2; instr_dst = 3'd5;
        tick();
        instr_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        rd_addr = 3'd5;
        #1;
        n_vec++;
        if (rd_data !== 16'h0 || carry_flag !== 1'b0 || compare_flag !== 1'b0 ||
            res_valid !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_exec: rf5=%h carry=%b cmp=%b valid=%b ready=%b want 0 0 0 0 1",
                     rd_data, carry_flag, compare_flag, res_valid, instr_ready);
        end
    endtask

    task automatic test_random();
        logic [3:0]  sel;
        logic        mode;
        logic        uc;
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic [2:0]  dst;
        logic        la;
        logic        le;
        logic [2:0]  laa;
        logic [2:0]  lea;
        int          hold;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) ld(3'($urandom), 16'($urandom));
            sel  = 4'($urandom);
            mode = 1'($urandom);
            uc   = 1'($urandom);
            sa   = 3'($urandom);
            sb   = 3'($urandom);
            dst  = 3'($urandom);
            la   = ($urandom_range(0, 3) == 0);
            le   = ($urandom_range(0, 3) == 0);
            laa  = ($urandom_range(0, 1) == 0) ? sa : 3'($urandom);
            lea  = ($urandom_range(0, 1) == 0) ? dst : 3'($urandom);
            hold = $urandom_range(0, 2);
            run_instr(sel, mode, uc, sa, sb, dst, la, laa, 16'($urandom), le, lea,
                      16'($urandom), hold, w, ve, vr, st, od, ot);
            n_vec++;
            if (w !== 0 || ve !== 1'b0 || vr !== 1'b1 || st !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd%0d_handshake: wait=%0d v_exec=%b v_resp=%b stable=%b want 0 0 1 1",
                         n, w, ve, vr, st);
            end
            n_vec++;
            if (od !== exp_res || ot !== dst) begin
                n_fail++;
                $display("FAIL rnd%0d_result: res=%h dst=%0d want %h %0d", n, od, ot, exp_res, dst);
            end
            n_vec++;
            if (carry_flag !== m_carry || compare_flag !== m_cmp) begin
                n_fail++;
                $display("FAIL rnd%0d_flags: carry=%b cmp=%b want %b %b",
                         n, carry_flag, compare_flag, m_carry, m_cmp);
            end
            for (int i = 0; i < 8; i++) begin
                rd_addr = 3'(i);
                #1;
                n_vec++;
                if (rd_data !== m_rf[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_rf[%0d]: got %h want %h", n, i, rd_data, m_rf[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0; instr_select = '0; instr_mode = 1'b0; instr_use_carry = 1'b0;
        instr_src_a = '0; instr_src_b = '0; instr_dst = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        res_ready = 1'b0; rd_addr = '0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_xor();
        test_arith();
        test_backpressure();
        test_collision();
        test_reset_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
